// File: rtl/clint_timer_pkg.sv
// Shared constants and types for the CLINT machine timer.
// Register offsets, mtimecmp reset value, bus FSM state.
package clint_timer_pkg;

  localparam int CLINT_DATA_W = 32;

  localparam logic [31:0] CLINT_MSIP        = 32'h00;
  localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h04;
  localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h08;
  localparam logic [31:0] CLINT_MTIME_LO    = 32'h0C;
  localparam logic [31:0] CLINT_MTIME_HI    = 32'h10;

  localparam logic [63:0] CLINT_MTIMECMP_RESET =
    64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE,
    RESP
  } bus_state_e;

endpackage

// File: rtl/clint_timer_if.sv
// Single-outstanding valid/ready request/response bus.
// master = requester (core), slave = clint_timer.
interface clint_timer_if
  import clint_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_address;
  logic [CLINT_DATA_W-1:0] req_wdata;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [CLINT_DATA_W-1:0] resp_rdata;
  logic                    resp_error;

  modport master (
    output req_valid, req_write,
    output req_address, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write,
    input  req_address, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_error
  );
endinterface

// File: rtl/clint_mtime_counter.sv
// Prescaled free-running 64-bit mtime with 32-bit half loads.
// Ports: clk, rst_n, load_lo/load_hi/load_data, mtime.
module clint_mtime_counter
  import clint_timer_pkg::*;
#(
  parameter int PRESCALE       = 1,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_lo,
  input  logic                    load_hi,
  input  logic [CLINT_DATA_W-1:0] load_data,
  output logic [63:0]             mtime
);

  logic [PRESCALE_WIDTH-1:0] pre;
  logic                      tick;

  assign tick = (pre == PRESCALE_WIDTH'(PRESCALE - 1));

  // A load beats the tick and restarts the prescale period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      mtime <= '0;
    end else if (load_lo || load_hi) begin
      pre <= '0;
      if (load_lo) mtime[31:0]  <= load_data;
      if (load_hi) mtime[63:32] <= load_data;
    end else if (tick) begin
      pre   <= '0;
      mtime <= mtime + 64'd1;
    end else begin
      pre <= pre + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/clint_timer.sv
// CLINT-style machine timer and software interrupt source.
// Ports: clk, rst_n, bus (slave), timer_irq, soft_irq.
// Option: CLINT_MTIME_SNAPSHOT_EN gives tear-free mtime reads.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int PRESCALE       = 1,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  clint_timer_if.slave bus,
  output logic         timer_irq,
  output logic         soft_irq
);

  bus_state_e state, state_nxt;

  logic                  accept;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           addr;
  logic                  hit_msip;
  logic                  hit_cmp_lo;
  logic                  hit_cmp_hi;
  logic                  hit_mt_lo;
  logic                  hit_mt_hi;
  logic                  hit_any;
  logic [31:0]           rdata_nxt;
  logic [31:0]           rdata_q;
  logic                  error_q;
  logic                  msip;
  logic [63:0]           mtimecmp;
  logic [63:0]           mtime;
  logic [31:0]           mt_hi_rd;

  assign req_addr = bus.req_address;
  assign addr     = 32'(req_addr);

  // Offsets are word aligned, so a misaligned
  // address never hits and falls into the error path.
  assign hit_msip   = (addr == CLINT_MSIP);
  assign hit_cmp_lo = (addr == CLINT_MTIMECMP_LO);
  assign hit_cmp_hi = (addr == CLINT_MTIMECMP_HI);
  assign hit_mt_lo  = (addr == CLINT_MTIME_LO);
  assign hit_mt_hi  = (addr == CLINT_MTIME_HI);
  assign hit_any    = hit_msip | hit_cmp_lo | hit_cmp_hi
                    | hit_mt_lo | hit_mt_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr = accept && bus.req_write;

  clint_mtime_counter #(
    .PRESCALE       (PRESCALE),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_mtime (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_lo   (wr && hit_mt_lo),
    .load_hi   (wr && hit_mt_hi),
    .load_data (bus.req_wdata),
    .mtime     (mtime)
  );

`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [31:0] snap;

  // A low-half read freezes the high half for the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      snap <= '0;
    else if (accept && !bus.req_write && hit_mt_lo)
      snap <= mtime[63:32];
  end

  assign mt_hi_rd = snap;
`else
  assign mt_hi_rd = mtime[63:32];
`endif

  always_comb begin
    rdata_nxt = '0;
    unique case (1'b1)
      hit_msip:   rdata_nxt = {31'b0, msip};
      hit_cmp_lo: rdata_nxt = mtimecmp[31:0];
      hit_cmp_hi: rdata_nxt = mtimecmp[63:32];
      hit_mt_lo:  rdata_nxt = mtime[31:0];
      hit_mt_hi:  rdata_nxt = mt_hi_rd;
      default:    rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (accept) begin
      rdata_q <= bus.req_write ? '0 : rdata_nxt;
      error_q <= !hit_any;
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;

  // Compare uses pre-edge values, so irq lags by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip      <= 1'b0;
      mtimecmp  <= CLINT_MTIMECMP_RESET;
      timer_irq <= 1'b0;
    end else begin
      if (wr && hit_msip)   msip <= bus.req_wdata[0];
      if (wr && hit_cmp_lo) mtimecmp[31:0]  <= bus.req_wdata;
      if (wr && hit_cmp_hi) mtimecmp[63:32] <= bus.req_wdata;
      timer_irq <= (mtime >= mtimecmp);
    end
  end

  assign soft_irq = msip;

endmodule
